// File: rtl/me_search_sequencer_pkg.sv
// Shared motion-estimation types and constants for the search sequencer.
//   mv_t    : 14-bit packed MV, [13:7] signed x, [6:0] signed y
//   state_t : sequencer states
package me_search_sequencer_pkg;

  typedef struct packed {
    logic signed [6:0] x;
    logic signed [6:0] y;
  } mv_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_PRED,
    WAIT_PRED,
    ISSUE_EXT,
    WAIT_EXT,
    DONE
  } state_t;

  localparam int DEF_EXT_STEP    = 4;
  localparam int DEF_MV_LIM      = 63;
  localparam int DEF_WDOG_CYCLES = 255;

  localparam int NUM_PRED = 3;
  localparam int NUM_EXT  = 5;

endpackage

// File: rtl/me_search_sequencer_mv_offset_sat.sv
// mv_offset_sat: combinational MV + (dx,dy) with per-component saturation
// to +/-MV_LIM.
//   mv_in  : base MV
//   dx, dy : signed offsets
//   mv_out : saturated result
module mv_offset_sat
  import me_search_sequencer_pkg::*;
#(
  parameter int MV_LIM = DEF_MV_LIM
) (
  input  logic [13:0]       mv_in,
  input  logic signed [7:0] dx,
  input  logic signed [7:0] dy,
  output logic [13:0]       mv_out
);

  localparam logic signed [8:0] LIM_P = 9'(MV_LIM);
  localparam logic signed [8:0] LIM_N = -LIM_P;

  function automatic logic signed [6:0] sat_add(input logic signed [6:0] c,
                                                input logic signed [7:0] d);
    logic signed [8:0] s;
    s = 9'(c) + 9'(d);
    if (s > LIM_P)
      s = LIM_P;
    else if (s < LIM_N)
      s = LIM_N;
    return s[6:0];
  endfunction

  mv_t base;
  mv_t res;

  assign base   = mv_in;
  assign res.x  = sat_add(base.x, dx);
  assign res.y  = sat_add(base.y, dy);
  assign mv_out = res;

endmodule

// File: rtl/me_search_sequencer.sv
// me_search_sequencer: issues three predictor MVs to the SAD engine, an
// optional five-point clamped diamond around predictor 0, and returns the
// selector's chosen MV with a one-cycle done pulse.
//   clk, reset (async, active-low)
//   start, mv_pred0..2           : search request from MB control
//   eng_ready                    : SAD engine handshake
//   mv_cand, cand_we, cand_last,
//   extended                     : candidate stream to the selector
//   sel_done, sel_goext, sel_mv  : selector response
//   busy, done, mv_final,
//   ext_used, err                : status/result
// Optional: SEARCH_SEQ_WATCHDOG_EN adds a WAIT-state timeout (WDOG_CYCLES).
module me_search_sequencer
  import me_search_sequencer_pkg::*;
#(
  parameter int EXT_STEP    = DEF_EXT_STEP,
  parameter int MV_LIM      = DEF_MV_LIM,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] mv_pred0,
  input  logic [13:0] mv_pred1,
  input  logic [13:0] mv_pred2,
  input  logic        eng_ready,
  output logic [13:0] mv_cand,
  output logic        cand_we,
  output logic        cand_last,
  output logic        extended,
  input  logic        sel_done,
  input  logic        sel_goext,
  input  logic [13:0] sel_mv,
  output logic        busy,
  output logic        done,
  output logic [13:0] mv_final,
  output logic        ext_used,
  output logic        err
);

  localparam logic signed [7:0] STEP_P = 8'(EXT_STEP);
  localparam logic signed [7:0] STEP_N = -STEP_P;

  state_t            state, state_nx;
  logic [2:0]        idx, idx_nx;
  mv_t               pred0_q, pred1_q, pred2_q;
  logic              pred_ld;
  mv_t               pred_sel;
  mv_t               ext_base;
  logic [13:0]       ext_mv;
  logic signed [7:0] ext_dx, ext_dy;
  logic [13:0]       mv_cand_nx, mv_final_nx;
  logic              cand_we_nx, cand_last_nx, extended_nx, done_nx;
  logic              ext_used_nx, err_nx;
  logic              wd_expire;

  always_comb begin
    case (idx)
      3'd0:    pred_sel = pred0_q;
      3'd1:    pred_sel = pred1_q;
      default: pred_sel = pred2_q;
    endcase
  end

  // Diamond order: +x, -x, +y, -y, then the zero vector.
  always_comb begin
    ext_base = pred0_q;
    ext_dx   = '0;
    ext_dy   = '0;
    case (idx)
      3'd0:    ext_dx = STEP_P;
      3'd1:    ext_dx = STEP_N;
      3'd2:    ext_dy = STEP_P;
      3'd3:    ext_dy = STEP_N;
      default: ext_base = '0;
    endcase
  end

  mv_offset_sat #(.MV_LIM(MV_LIM)) u_sat (
    .mv_in (ext_base),
    .dx    (ext_dx),
    .dy    (ext_dy),
    .mv_out(ext_mv)
  );

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    pred_ld      = 1'b0;
    mv_cand_nx   = mv_cand;
    cand_we_nx   = 1'b0;
    cand_last_nx = 1'b0;
    extended_nx  = extended;
    done_nx      = 1'b0;
    mv_final_nx  = mv_final;
    ext_used_nx  = ext_used;
    err_nx       = err;
    case (state)
      IDLE: begin
        if (start) begin
          pred_ld     = 1'b1;
          ext_used_nx = 1'b0;
          err_nx      = 1'b0;
          idx_nx      = '0;
          state_nx    = ISSUE_PRED;
        end
      end
      ISSUE_PRED: begin
        if (eng_ready) begin
          mv_cand_nx = pred_sel;
          cand_we_nx = 1'b1;
          if (idx == 3'(NUM_PRED - 1)) begin
            cand_last_nx = 1'b1;
            idx_nx       = '0;
            state_nx     = WAIT_PRED;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      WAIT_PRED: begin
        if (sel_done) begin
          mv_final_nx = sel_mv;
          done_nx     = 1'b1;
          state_nx    = DONE;
        end else if (sel_goext) begin
          ext_used_nx = 1'b1;
          idx_nx      = '0;
          state_nx    = ISSUE_EXT;
        end else if (wd_expire) begin
          mv_final_nx = pred0_q;
          err_nx      = 1'b1;
          done_nx     = 1'b1;
          state_nx    = DONE;
        end
      end
      ISSUE_EXT: begin
        if (eng_ready) begin
          mv_cand_nx  = ext_mv;
          cand_we_nx  = 1'b1;
          // extended rises with the first diamond candidate, not on goext.
          extended_nx = 1'b1;
          if (idx == 3'(NUM_EXT - 1)) begin
            cand_last_nx = 1'b1;
            idx_nx       = '0;
            state_nx     = WAIT_EXT;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      WAIT_EXT: begin
        if (sel_done) begin
          mv_final_nx = sel_mv;
          done_nx     = 1'b1;
          state_nx    = DONE;
        end else if (wd_expire) begin
          mv_final_nx = pred0_q;
          err_nx      = 1'b1;
          done_nx     = 1'b1;
          state_nx    = DONE;
        end
      end
      DONE: begin
        extended_nx = 1'b0;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      pred0_q   <= '0;
      pred1_q   <= '0;
      pred2_q   <= '0;
      mv_cand   <= '0;
      cand_we   <= 1'b0;
      cand_last <= 1'b0;
      extended  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mv_final  <= '0;
      ext_used  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      if (pred_ld) begin
        pred0_q <= mv_pred0;
        pred1_q <= mv_pred1;
        pred2_q <= mv_pred2;
      end
      mv_cand   <= mv_cand_nx;
      cand_we   <= cand_we_nx;
      cand_last <= cand_last_nx;
      extended  <= extended_nx;
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
      mv_final  <= mv_final_nx;
      ext_used  <= ext_used_nx;
      err       <= err_nx;
    end
  end

`ifdef SEARCH_SEQ_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        waiting;

  assign waiting = (state == WAIT_PRED) || (state == WAIT_EXT);

  // Restarts on every state change so WAIT_EXT gets a fresh budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wd_cnt <= '0;
    else if (!waiting || (state_nx != state))
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_expire = waiting && (wd_cnt == 32'(WDOG_CYCLES - 1));
`else
  // No watchdog: the WAIT states never time out.
  assign wd_expire = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_me_search_sequencer.sv
module tb_me_search_sequencer;

`ifdef SEARCH_SEQ_WATCHDOG_EN
  localparam int WD    = 8;
  localparam bit WD_ON = 1'b1;
`else
  localparam int WD    = 255;
  localparam bit WD_ON = 1'b0;
`endif
  localparam int STEP = 4;
  localparam int LIM  = 63;

  logic        clk, reset, start, eng_ready, sel_done, sel_goext;
  logic [13:0] mv_pred0, mv_pred1, mv_pred2, sel_mv;
  logic [13:0] mv_cand, mv_final;
  logic        cand_we, cand_last, extended, busy, done, ext_used, err;

  me_search_sequencer #(
    .EXT_STEP   (STEP),
    .MV_LIM     (LIM),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mv_pred0 (mv_pred0),
    .mv_pred1 (mv_pred1),
    .mv_pred2 (mv_pred2),
    .eng_ready(eng_ready),
    .mv_cand  (mv_cand),
    .cand_we  (cand_we),
    .cand_last(cand_last),
    .extended (extended),
    .sel_done (sel_done),
    .sel_goext(sel_goext),
    .sel_mv   (sel_mv),
    .busy     (busy),
    .done     (done),
    .mv_final (mv_final),
    .ext_used (ext_used),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: got no event within bound, expected event", name, $time);
  endtask

  function automatic logic [13:0] mv(input int x, input int y);
    logic [6:0] xs, ys;
    xs = 7'(x);
    ys = 7'(y);
    return {xs, ys};
  endfunction

  function automatic int comp_x(input logic [13:0] m);
    logic signed [6:0] t;
    t = m[13:7];
    return int'(t);
  endfunction

  function automatic int comp_y(input logic [13:0] m);
    logic signed [6:0] t;
    t = m[6:0];
    return int'(t);
  endfunction

  function automatic int clampc(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic logic [13:0] ext_cand(input logic [13:0] p, input int k);
    int x, y;
    x = comp_x(p);
    y = comp_y(p);
    case (k)
      0: x = x + STEP;
      1: x = x - STEP;
      2: y = y + STEP;
      3: y = y - STEP;
      default: begin x = 0; y = 0; end
    endcase
    return mv(clampc(x), clampc(y));
  endfunction

  // Behavioural reference: pending candidates kept as a queue.
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_DONE = 3;
  int          m_mode  = M_IDLE;
  int          m_wcnt  = 0;
  logic [13:0] q[$];
  logic [13:0] m_p0    = '0;
  logic [13:0] m_cand  = '0;
  logic [13:0] m_final = '0;
  bit m_we = 0, m_last = 0, m_ext = 0, m_busy = 0, m_done = 0;
  bit m_used = 0, m_err = 0, m_inext = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_wcnt = 0; q.delete();
      m_p0 = '0; m_cand = '0; m_final = '0;
      m_we = 0; m_last = 0; m_ext = 0; m_busy = 0; m_done = 0;
      m_used = 0; m_err = 0; m_inext = 0;
    end else begin
      m_we = 0; m_last = 0; m_done = 0;
      case (m_mode)
        M_IDLE: if (start) begin
          q.delete();
          q.push_back(mv_pred0); q.push_back(mv_pred1); q.push_back(mv_pred2);
          m_p0 = mv_pred0; m_used = 0; m_err = 0; m_inext = 0;
          m_mode = M_ISSUE;
        end
        M_ISSUE: if (eng_ready) begin
          m_cand = q.pop_front();
          m_we = 1;
          if (m_inext) m_ext = 1;
          if (q.size() == 0) begin
            m_last = 1; m_mode = M_WAIT; m_wcnt = 0;
          end
        end
        M_WAIT: begin
          if (sel_done) begin
            m_final = sel_mv; m_done = 1; m_mode = M_DONE;
          end else if (sel_goext && !m_inext) begin
            for (int k = 0; k < 5; k++) q.push_back(ext_cand(m_p0, k));
            m_inext = 1; m_used = 1; m_mode = M_ISSUE;
          end else begin
            m_wcnt++;
            if (WD_ON && m_wcnt == WD) begin
              m_final = m_p0; m_err = 1; m_done = 1; m_mode = M_DONE;
            end
          end
        end
        default: begin m_ext = 0; m_mode = M_IDLE; end
      endcase
      m_busy = (m_mode != M_IDLE);
    end
  end

  logic [13:0] seen[$];

  always @(negedge clk) begin
    if (cand_we) seen.push_back(mv_cand);
    check("busy",      busy,      m_busy);
    check("cand_we",   cand_we,   m_we);
    check("cand_last", cand_last, m_last);
    check("mv_cand",   mv_cand,   m_cand);
    check("extended",  extended,  m_ext);
    check("done",      done,      m_done);
    check("mv_final",  mv_final,  m_final);
    check("ext_used",  ext_used,  m_used);
    check("err",       err,       m_err);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_search(input logic [13:0] p0, input logic [13:0] p1, input logic [13:0] p2);
    int t;
    t = 0;
    while (busy && t < 200) begin step(); t++; end
    if (busy) timeout_fail("idle_wait");
    mv_pred0 = p0; mv_pred1 = p1; mv_pred2 = p2;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_last(input string tag);
    int t;
    t = 0;
    do begin step(); t++; end while (!cand_last && t < 100);
    if (!cand_last) timeout_fail(tag);
  endtask

  task automatic finish_search(input logic [13:0] m);
    sel_mv = m; sel_done = 1'b1;
    step();
    sel_done = 1'b0;
    step();
  endtask

  bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; start = 0; eng_ready = 0; sel_done = 0; sel_goext = 0;
    mv_pred0 = '0; mv_pred1 = '0; mv_pred2 = '0; sel_mv = '0;
    #1 reset = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_mv_final", mv_final, 0);
    check("rst_cand_we", cand_we, 0);
    reset = 1'b1;
    step();

    // Basic predictor pass
    eng_ready = 1'b1;
    seen.delete();
    start_search(mv(1, 2), mv(3, 4), mv(-5, 6));
    wait_last("basic_last");
    check("basic_n", seen.size(), 3);
    check("basic_c0", seen[0], mv(1, 2));
    check("basic_c1", seen[1], mv(3, 4));
    check("basic_c2", seen[2], mv(-5, 6));
    sel_mv = mv(3, 4); sel_done = 1'b1;
    step();
    sel_done = 1'b0;
    check("basic_done", done, 1);
    check("basic_final", mv_final, mv(3, 4));
    check("basic_ext_used", ext_used, 0);
    step();
    check("basic_done_pulse", done, 0);
    check("basic_idle", busy, 0);

    // Extended diamond
    start_search(mv(10, -10), mv(0, 1), mv(1, 0));
    wait_last("ext_pred_last");
    sel_goext = 1'b1;
    step();
    sel_goext = 1'b0;
    seen.delete();
    wait_last("ext_last");
    check("ext_n", seen.size(), 5);
    check("ext_c0", seen[0], mv(14, -10));
    check("ext_c1", seen[1], mv(6, -10));
    check("ext_c2", seen[2], mv(10, -6));
    check("ext_c3", seen[3], mv(10, -14));
    check("ext_c4", seen[4], mv(0, 0));
    check("ext_flag", extended, 1);
    sel_mv = mv(14, -10); sel_done = 1'b1;
    step();
    sel_done = 1'b0;
    check("ext_done", done, 1);
    check("ext_used", ext_used, 1);
    check("ext_flag_with_done", extended, 1);
    step();
    check("ext_flag_cleared", extended, 0);

    // Saturation
    start_search(mv(61, -62), mv(1, 1), mv(2, 2));
    wait_last("sat_pred_last");
    sel_goext = 1'b1;
    step();
    sel_goext = 1'b0;
    seen.delete();
    wait_last("sat_last");
    check("sat_c0", seen[0], mv(63, -62));
    check("sat_c1", seen[1], mv(57, -62));
    check("sat_c3", seen[3], mv(61, -63));
    finish_search(mv(5, 5));

    // Stall
    eng_ready = 1'b0;
    seen.delete();
    start_search(mv(7, -3), mv(-8, 2), mv(20, 21));
    foreach (pat[i]) begin
      eng_ready = pat[i];
      step();
      check("stall_we", cand_we, pat[i]);
      if (i == 1 || i == 2) check("stall_hold", mv_cand, mv(7, -3));
    end
    check("stall_last", cand_last, 1);
    check("stall_n", seen.size(), 3);
    check("stall_c1", seen[1], mv(-8, 2));
    check("stall_c2", seen[2], mv(20, 21));
    eng_ready = 1'b1;
    finish_search(mv(20, 21));

    // sel_done and sel_goext together
    start_search(mv(3, 3), mv(4, 4), mv(5, 5));
    wait_last("both_last");
    sel_mv = mv(7, 7); sel_done = 1'b1; sel_goext = 1'b1;
    step();
    sel_done = 1'b0; sel_goext = 1'b0;
    check("both_done", done, 1);
    check("both_ext_used", ext_used, 0);
    step(); step();
    check("both_no_ext", cand_we, 0);
    check("both_idle", busy, 0);

    // start while busy
    start_search(mv(1, 1), mv(2, 2), mv(3, 3));
    wait_last("busy_last");
    mv_pred0 = mv(30, 30); start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("busy_ignored", cand_we, 0);
    check("busy_still", busy, 1);
    finish_search(mv(2, 2));

    // Reset during ISSUE_EXT
    start_search(mv(9, 9), mv(2, 2), mv(3, 3));
    wait_last("rst_pred_last");
    sel_goext = 1'b1;
    step();
    sel_goext = 1'b0;
    step();
    check("rst_pre_ext", extended, 1);
    reset = 1'b0;
    #1;
    check("rstx_busy", busy, 0);
    check("rstx_we", cand_we, 0);
    check("rstx_ext", extended, 0);
    check("rstx_cand", mv_cand, 0);
    check("rstx_ext_used", ext_used, 0);
    step();
    reset = 1'b1;
    step();

    // Watchdog
    start_search(mv(-12, 40), mv(2, 2), mv(3, 3));
    wait_last("wd_last");
`ifdef SEARCH_SEQ_WATCHDOG_EN
    begin
      int n;
      n = 0;
      do begin step(); n++; end while (!done && n < 20);
      check("wd_latency", n, WD);
      check("wd_err", err, 1);
      check("wd_final", mv_final, mv(-12, 40));
      step();
    end
`else
    repeat (1000) step();
    check("nowd_busy", busy, 1);
    check("nowd_err", err, 0);
    finish_search(mv(1, 1));
`endif

    // Randomized traffic against the reference model
    for (int seg = 0; seg < 30; seg++) begin
      for (int c = 0; c < 60; c++) begin
        start     = ($urandom_range(0, 4) == 0);
        mv_pred0  = 14'($urandom);
        mv_pred1  = 14'($urandom);
        mv_pred2  = 14'($urandom);
        eng_ready = ($urandom_range(0, 2) != 0);
        sel_done  = ($urandom_range(0, 5) == 0);
        sel_goext = ($urandom_range(0, 2) == 0);
        sel_mv    = 14'($urandom);
        step();
      end
      if ($urandom_range(0, 2) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
    end

    start = 0; sel_done = 0; sel_goext = 0; eng_ready = 1;
    repeat (5) step();
    sel_done = 1'b1;
    repeat (12) step();
    sel_done = 1'b0;
    repeat (3) step();
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
